// File: rtl/reset_sequencer.sv
// Releases N reset domains in order after system reset, waiting on each domain's ack.
// Recovers from a missing or lost ack by asserting every domain again and restarting.
module reset_sequencer #(
    parameter int N_DOMAINS      = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STEP_CYCLES    = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic                                             sw_rst_req,
    input  logic [N_DOMAINS-1:0]                             domain_ack,
    output logic [N_DOMAINS-1:0]                             domain_rst_n,
    output logic                                             all_up,
    output logic                                             fault,
    output logic [(N_DOMAINS > 1 ? $clog2(N_DOMAINS) : 1)-1:0] fault_domain
);

    // state    | meaning
    // ST_HOLD  | every domain held in reset for HOLD_CYCLES
    // ST_WAIT  | domain idx released, waiting for its ack or a timeout
    // ST_GAP   | domain idx acked, spacing before the next release
    // ST_UP    | all domains released and acked, watching for ack loss

    localparam int IW     = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
    localparam int MAX_HS = (HOLD_CYCLES > STEP_CYCLES) ? HOLD_CYCLES : STEP_CYCLES;
    localparam int CNT_MX = (MAX_HS > TIMEOUT_CYCLES) ? MAX_HS : TIMEOUT_CYCLES;
    localparam int CW     = $clog2(CNT_MX + 1);

    typedef enum logic [1:0] {
        ST_HOLD,
        ST_WAIT,
        ST_GAP,
        ST_UP
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [N_DOMAINS-1:0]   drn_q, drn_d;
    logic                   all_up_q, all_up_d;
    logic                   fault_q, fault_d;
    logic [IW-1:0]          fd_q, fd_d;
    logic                   do_fault;
    logic [IW-1:0]          fault_idx;
    logic [IW-1:0]          low_idx;

    always_comb begin
        low_idx = '0;
        for (int i = N_DOMAINS - 1; i >= 0; i--) begin
            if (!domain_ack[i]) low_idx = IW'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
        idx_d     = idx_q;
        drn_d     = drn_q;
        all_up_d  = all_up_q;
        fault_d   = fault_q;
        fd_d      = fd_q;
        do_fault  = 1'b0;
        fault_idx = '0;

        if (sw_rst_req) begin
            state_d  = ST_HOLD;
            cnt_d    = '0;
            idx_d    = '0;
            drn_d    = '0;
            all_up_d = 1'b0;
            fault_d  = 1'b0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    drn_d = '0;
                    if (cnt_q == CW'(HOLD_CYCLES - 1)) begin
                        drn_d    = N_DOMAINS'(1);
                        idx_d    = '0;
                        cnt_d    = '0;
                        state_d  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // an ack on the timeout edge still wins
                    if (domain_ack[idx_q]) begin
                        cnt_d = '0;
                        if (idx_q == IW'(N_DOMAINS - 1)) begin
                            state_d  = ST_UP;
                            all_up_d = 1'b1;
                        end else begin
                            state_d = ST_GAP;
                        end
                    end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        do_fault  = 1'b1;
                        fault_idx = idx_q;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == CW'(STEP_CYCLES - 1)) begin
                        idx_d   = idx_q + IW'(1);
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                        for (int i = 0; i < N_DOMAINS; i++) begin
                            if (i == int'(idx_q) + 1) drn_d[i] = 1'b1;
                        end
                    end
                end
                ST_UP: begin
                    if (!(&domain_ack)) begin
                        do_fault  = 1'b1;
                        fault_idx = low_idx;
                    end
                end
                default: state_d = ST_HOLD;
            endcase

            if (do_fault) begin
                drn_d    = '0;
                all_up_d = 1'b0;
                fault_d  = 1'b1;
                fd_d     = fault_idx;
                idx_d    = '0;
                cnt_d    = '0;
                state_d  = ST_HOLD;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HOLD;
            cnt_q    <= '0;
            idx_q    <= '0;
            drn_q    <= '0;
            all_up_q <= 1'b0;
            fault_q  <= 1'b0;
            fd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            drn_q    <= drn_d;
            all_up_q <= all_up_d;
            fault_q  <= fault_d;
            fd_q     <= fd_d;
        end
    end

    assign domain_rst_n = drn_q;
    assign all_up       = all_up_q;
    assign fault        = fault_q;
    assign fault_domain = fd_q;

endmodule
